// File: rtl/mux2_rr_stage.sv
// Two-channel round-robin arbiter feeding a registered 2:1 mux stage.
// Define MUX2_RR_BURST_EN to let a channel hold the grant for up to BURST words.
module mux2_rr_stage #(
   parameter int WIDTH = 4,
   parameter int BURST = 4
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic [WIDTH-1:0] I0,
   input  logic             V0,
   output logic             R0,
   input  logic [WIDTH-1:0] I1,
   input  logic             V1,
   output logic             R1,
   output logic             S,
   output logic [WIDTH-1:0] O,
   output logic             OV,
   input  logic             OR
);

   if (BURST < 1 || BURST > 15) begin : g_bad_burst
      $error("BURST must be in 1..15");
   end

   logic [WIDTH-1:0] o_q;
   logic             ov_q;
   logic             s_q;
   logic             last_q;
   logic             load;
   logic             has_gnt;
   logic             gnt;
   logic             keep;
   logic             xfer;

`ifdef MUX2_RR_BURST_EN
   logic [3:0] cnt_q;

   // cnt_q == 0 only right after reset, where nobody owns the grant yet
   assign keep = (cnt_q != 4'd0) && (cnt_q < 4'(BURST));

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         cnt_q <= 4'd0;
      end else if (xfer) begin
         if (gnt == last_q && cnt_q != 4'd0) begin
            if (cnt_q != 4'hF) cnt_q <= cnt_q + 4'd1;
         end else begin
            cnt_q <= 4'd1;
         end
      end
   end
`else
   assign keep = 1'b0;
`endif

   always_comb begin
      load    = !ov_q | OR;
      has_gnt = V0 | V1;
      gnt     = 1'b0;
      unique case (1'b1)
         (V0 & V1):  gnt = keep ? last_q : !last_q;
         (!V0 & V1): gnt = 1'b1;
         default:    gnt = 1'b0;
      endcase
      xfer = load & has_gnt;
   end

   assign R0 = RESETN & load & has_gnt & !gnt & V0;
   assign R1 = RESETN & load & has_gnt & gnt & V1;
   assign S  = RESETN & (has_gnt ? gnt : s_q);
   assign O  = o_q;
   assign OV = ov_q;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         o_q    <= '0;
         ov_q   <= 1'b0;
         s_q    <= 1'b0;
         last_q <= 1'b1;
      end else begin
         if (has_gnt) s_q <= gnt;
         if (xfer) begin
            o_q    <= gnt ? I1 : I0;
            ov_q   <= 1'b1;
            last_q <= gnt;
         end else if (OR) begin
            ov_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux2_rr_stage.sv
// Scoreboard bench for mux2_rr_stage: directed vectors, queued expectations.
// A negedge monitor pops and compares every word the consumer takes.
module tb_mux2_rr_stage;

   localparam int W = 4;
`ifdef MUX2_RR_BURST_EN
   localparam int BURST = 2;
`else
   localparam int BURST = 4;
`endif

   logic         CLK = 1'b0;
   logic         RESETN = 1'b0;
   logic [W-1:0] I0 = '0;
   logic         V0 = 1'b0;
   logic         R0;
   logic [W-1:0] I1 = '0;
   logic         V1 = 1'b0;
   logic         R1;
   logic         S;
   logic [W-1:0] O;
   logic         OV;
   logic         OR = 1'b0;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

`ifdef MUX2_RR_BURST_EN
   logic [W-1:0] seq_o [6] = '{4'hA, 4'hA, 4'h5, 4'h5, 4'hA, 4'hA};
   logic         seq_s [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`else
   logic [W-1:0] seq_o [6] = '{4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5};
   logic         seq_s [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif

   mux2_rr_stage #(.WIDTH(W), .BURST(BURST)) dut (
      .CLK(CLK), .RESETN(RESETN),
      .I0(I0), .V0(V0), .R0(R0),
      .I1(I1), .V1(V1), .R1(R1),
      .S(S), .O(O), .OV(OV), .OR(OR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   always @(negedge CLK) begin
      if (RESETN === 1'b1 && OV === 1'b1 && OR === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected actual=%0h required=none", O);
         end else begin
            chk("out_data", 32'(O), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      repeat (2) step();
      #2;
      chk("rst_ov", OV, 0);
      chk("rst_o", O, 0);
      chk("rst_s", S, 0);
      chk("rst_r0", R0, 0);
      chk("rst_r1", R1, 0);

      step();
      RESETN = 1'b1;
      #2;
      chk("idle_ov", OV, 0);
      chk("idle_o", O, 0);
      chk("idle_s", S, 0);
      chk("idle_r0", R0, 0);
      chk("idle_r1", R1, 0);

      // single producer on channel 0
      step();
      V0 = 1'b1; I0 = 4'h3; OR = 1'b1;
      exp_q.push_back(4'h3);
      #2;
      chk("single_r0", R0, 1);
      chk("single_r1", R1, 0);
      chk("single_s", S, 0);
      step();
      V0 = 1'b0;
      #2;
      chk("single_ov", OV, 1);
      chk("single_o", O, 4'h3);
      chk("single_s_hold", S, 0);
      step();
      OR = 1'b0;
      #2;
      chk("drain_ov", OV, 0);
      chk("drain_o_hold", O, 4'h3);

      // load 7, then hold it under backpressure while V1 waits
      V0 = 1'b1; I0 = 4'h7;
      exp_q.push_back(4'h7);
      step();
      V0 = 1'b0; V1 = 1'b1; I1 = 4'h6;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("bp_o", O, 4'h7);
         chk("bp_ov", OV, 1);
         chk("bp_r0", R0, 0);
         chk("bp_r1", R1, 0);
         chk("bp_s", S, 1);
         step();
      end
      OR = 1'b1;
      exp_q.push_back(4'h6);
      #2;
      chk("bp_release_r1", R1, 1);
      step();

      // drain and refill on the same edge
      I1 = 4'hC;
      exp_q.push_back(4'hC);
      #2;
      chk("thru_ov", OV, 1);
      chk("thru_o", O, 4'h6);
      chk("thru_r1", R1, 1);
      step();
      V1 = 1'b0; OR = 1'b0;
      #2;
      chk("nobubble_ov", OV, 1);
      chk("nobubble_o", O, 4'hC);

      // asynchronous reset drops the held word
      #1;
      RESETN = 1'b0;
      exp_q.delete();
      #1;
      chk("arst_ov", OV, 0);
      chk("arst_o", O, 0);
      chk("arst_s", S, 0);
      chk("arst_r0", R0, 0);
      chk("arst_r1", R1, 0);
      step();
      step();
      RESETN = 1'b1;

      // continuous contention, first grant goes to channel 0
      V0 = 1'b1; V1 = 1'b1; I0 = 4'hA; I1 = 4'h5; OR = 1'b1;
      for (int i = 0; i < 6; i++) exp_q.push_back(seq_o[i]);
      for (int i = 0; i < 6; i++) begin
         #2;
         chk($sformatf("contend_s%0d", i), S, seq_s[i]);
         step();
      end
      V0 = 1'b0; V1 = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      #2;
      chk("final_queue_empty", exp_q.size(), 0);
      chk("final_ov", OV, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
